// File: rtl/ddr_dq_burst.sv
// DDR2 DQ burst sequencer: places write bursts on d0/d1/oe at WL, captures read
// bursts from o0/o1 at RL, and rejects starts whose bus window is already taken.
module ddr_dq_burst #(
  parameter int BANK_WIDTH   = 16,
  parameter int WL           = 3,
  parameter int RL           = 4,
  parameter int BURST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_start,
  input  logic                    rd_start,
  input  logic [2*BANK_WIDTH-1:0] wr_data,
  output logic                    wr_data_req,
  output logic [BANK_WIDTH-1:0]   d0,
  output logic [BANK_WIDTH-1:0]   d1,
  output logic                    oe,
  input  logic [BANK_WIDTH-1:0]   o0,
  input  logic [BANK_WIDTH-1:0]   o1,
  output logic [2*BANK_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    cmd_err,
  output logic                    busy
);

  localparam int MAX_LAT = (WL > RL) ? WL : RL;
  localparam int DEPTH   = MAX_LAT + BURST_CYCLES + 1;

  typedef logic [DEPTH-1:0] slot_t;

  function automatic slot_t span(input int lo, input int hi);
    slot_t m;
    for (int k = 0; k < DEPTH; k++) m[k] = (k >= lo) && (k <= hi);
    return m;
  endfunction

  // Bit k of each slot vector stands for the cycle k cycles after the current one.
  // CHK masks are tested against the current state; SET masks are already
  // shifted by one because they land in the next state.
  localparam slot_t WR_CHK = span(WL, WL + BURST_CYCLES - 1);
  localparam slot_t RD_CHK = span(RL - 1, RL + BURST_CYCLES);
  localparam slot_t WR_SET = span(WL - 1, WL + BURST_CYCLES - 2);
  localparam slot_t RD_SET = span(RL - 1, RL + BURST_CYCLES - 2);
  localparam slot_t RD_OCC = span(RL - 2, RL + BURST_CYCLES - 1);
  localparam logic  WR_IMM = (WL == 2);

  slot_t                   wr_slot_q, wr_slot_d;
  slot_t                   rd_slot_q, rd_slot_d;
  slot_t                   occ_q, occ_d;
  logic [BANK_WIDTH-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic                    oe_q, oe_d;
  logic                    req_q, req_d;
  logic [2*BANK_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    cmd_err_q, cmd_err_d;
  logic                    busy_q, busy_d;
  logic                    wr_ok, rd_ok, drive_next;

  always_comb begin
    wr_ok = wr_start && ((occ_q & WR_CHK) == '0);
    // A read sharing its cycle with a write is never taken, free or not.
    rd_ok = rd_start && !wr_start && ((occ_q & RD_CHK) == '0);

    wr_slot_d = (wr_slot_q >> 1) | (wr_ok ? WR_SET : '0);
    rd_slot_d = (rd_slot_q >> 1) | (rd_ok ? RD_SET : '0);
    occ_d     = (occ_q >> 1) | (wr_ok ? WR_SET : '0) | (rd_ok ? RD_OCC : '0);

    drive_next = wr_slot_q[1];
    req_d      = wr_slot_q[2] | (wr_ok & WR_IMM);
    d0_d       = drive_next ? wr_data[BANK_WIDTH-1:0] : '0;
    d1_d       = drive_next ? wr_data[2*BANK_WIDTH-1:BANK_WIDTH] : '0;
    // The preamble cycle coincides with the data request cycle.
    oe_d       = !(drive_next || req_d);

    rd_valid_d = rd_slot_q[0];
    rd_data_d  = rd_slot_q[0] ? {o1, o0} : rd_data_q;

    cmd_err_d  = (wr_start && !wr_ok) || (rd_start && !rd_ok);
    busy_d     = |{occ_d, wr_slot_d, rd_slot_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      occ_q      <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      oe_q       <= 1'b1;
      req_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      occ_q      <= occ_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      oe_q       <= oe_d;
      req_q      <= req_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_data_req = req_q;
  assign d0          = d0_q;
  assign d1          = d1_q;
  assign oe          = oe_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign cmd_err     = cmd_err_q;
  assign busy        = busy_q;

endmodule
